dma_seq: RTL and testbench

Sequenced single-channel DMA engine that copies a programmable run of words from a synchronous-read ROM port to a RAM write port, one word per cycle, with wrapping base addresses and busy/done status. It replaces the one-word-per-start transfer block in the memory subsystem: software or the top-level controller loads source base, destination base and length, pulses `start_dma`, and the engine walks both address spaces on its own.

---
 rtl/dma_seq.sv | 148 ++++++++++++++
 tb/tb_dma_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_seq.sv
// Single-channel DMA sequencer: copies data_amt words from a synchronous-read ROM port
// to a RAM write port at one word per cycle, with wrapping base addresses.
module dma_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_dma,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  data_amt,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic                  valid_q, valid_d;
  logic                  rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  ram_wea_q, ram_wea_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;

  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    rd_cnt_d     = rd_cnt_q;
    valid_d      = rom_en_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    ram_wea_d    = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    words_done_d = words_done_q;

    unique case (state_q)
      StIdle: begin
        if (start_dma) begin
          busy_d       = 1'b1;
          words_done_d = '0;
          dst_ptr_d    = dst_base;
          if (data_amt == '0) begin
            state_d = StFinish;
          end else begin
            // First read is issued straight from the start edge.
            rom_en_d   = 1'b1;
            rom_addr_d = src_base;
            src_ptr_d  = src_base + 1'b1;
            rd_cnt_d   = data_amt - 1'b1;
            state_d    = (data_amt == LEN_WIDTH'(1)) ? StDrain : StRead;
          end
        end
      end
      StRead: begin
        rom_en_d   = 1'b1;
        rom_addr_d = src_ptr_q;
        src_ptr_d  = src_ptr_q + 1'b1;
        rd_cnt_d   = rd_cnt_q - 1'b1;
        if (rd_cnt_q == LEN_WIDTH'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Last write goes out when the pipe holds a word and no read is in flight.
        if (valid_q && !rom_en_q) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (valid_q) begin
      ram_wea_d    = 1'b1;
      ram_data_d   = rom_data;
      ram_addr_d   = dst_ptr_q;
      dst_ptr_d    = dst_ptr_q + 1'b1;
      words_done_d = words_done_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      rd_cnt_q     <= '0;
      valid_q      <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      ram_wea_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      valid_q      <= valid_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      ram_wea_q    <= ram_wea_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      words_done_q <= words_done_d;
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign ram_wea    = ram_wea_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_dma_seq.sv
// Directed bench for dma_seq: ROM/RAM models, a write scoreboard and cycle-exact status checks.
module tb_dma_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_dma = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] data_amt = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          ram_wea;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  logic [DW-1:0] rom_mem [DEPTH];
  logic [DW-1:0] ram_mem [DEPTH];

  dma_seq #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_dma (start_dma),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .data_amt  (data_amt),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_wea   (ram_wea),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy),
    .done      (done),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
    if (ram_wea) ram_mem[ram_addr] <= ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the next expected word, in order.
  always @(negedge clk) begin
    if (ram_wea === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(ram_wea), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(mon_e.addr));
        chk("ram_data", 32'(ram_data), 32'(mon_e.data));
      end
    end
  end

  // Starts a transfer at the next edge (E0) and checks every cycle up to the done cycle.
  // j1/j2: edge indices at which a stray start (other parameters) is presented.
  task automatic xfer(input int src, input int dst, input int n, input int j1, input int j2);
    int dk;
    int wexp;
    wr_t e;
    dk = (n == 0) ? 1 : n + 2;
    for (int i = 0; i < n; i++) begin
      e.addr = AW'((dst + i) % DEPTH);
      e.data = rom_mem[(src + i) % DEPTH];
      exp_q.push_back(e);
    end
    src_base = AW'(src);
    dst_base = AW'(dst);
    data_amt = LW'(n);
    start_dma = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= dk; k++) begin
      @(negedge clk);
      chk("rom_en", 32'(rom_en), 32'(k < n));
      if (k < n) chk("rom_addr", 32'(rom_addr), 32'((src + k) % DEPTH));
      chk("ram_wea", 32'(ram_wea), 32'(k >= 2 && k <= n + 1));
      chk("busy", 32'(busy), 32'(k < dk));
      chk("done", 32'(done), 32'(k == dk));
      wexp = (k < 2) ? 0 : ((k - 1 < n) ? k - 1 : n);
      chk("words_done", 32'(words_done), 32'(wexp));
      start_dma = (k + 1 == j1) || (k + 1 == j2);
      if (start_dma) begin
        src_base = 4'd9;
        dst_base = 4'd9;
        data_amt = 16'd3;
      end
    end
    start_dma = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = DW'(8'hA0 + i);

    // Reset held two cycles: all outputs zero.
    @(negedge clk);
    @(negedge clk);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ram_wea", 32'(ram_wea), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);

    // Start while reset is still high: no activity.
    data_amt = 16'd4;
    start_dma = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_start_rom_en", 32'(rom_en), 32'd0);
      chk("rst_start_busy", 32'(busy), 32'd0);
    end
    start_dma = 1'b0;
    reset = 1'b0;

    // Basic copy.
    xfer(0, 4, 4, 0, 0);
    for (int i = 0; i < 4; i++) chk("basic_ram_mem", 32'(ram_mem[4 + i]), 32'(8'hA0 + i));

    // Address wrap on both sides.
    xfer(14, 15, 3, 0, 0);

    // Zero length, then over-length with wrap and overwrite.
    xfer(0, 0, 0, 0, 0);
    xfer(3, 8, 20, 0, 0);

    // Stray starts during the transfer and at the done edge are ignored;
    // a start at E(N+3) is accepted.
    xfer(5, 2, 5, 2, 7);
    xfer(1, 10, 2, 0, 0);

    // Reset mid-transfer at E4: two words written, no done.
    for (int i = 0; i < 2; i++) begin
      mon_e.addr = AW'(i);
      mon_e.data = rom_mem[7 + i];
      exp_q.push_back(mon_e);
    end
    src_base = 4'd7;
    dst_base = 4'd0;
    data_amt = 16'd8;
    start_dma = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_dma = 1'b0;
      chk("abort_busy_before", 32'(busy), 32'd1);
      if (k == 3) reset = 1'b1;
    end
    @(negedge clk);
    chk("abort_rom_en", 32'(rom_en), 32'd0);
    chk("abort_ram_wea", 32'(ram_wea), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_words_done", 32'(words_done), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    chk("abort_scoreboard", 32'(exp_q.size()), 32'd0);

    // Fresh transfer after the abort.
    xfer(6, 12, 4, 0, 0);

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
